melody_sequencer: RTL and testbench

//  Plays a programmable note table by driving the shared sine/clkgen/DAC tone path.
//  Per note it outputs the pitch divider (maxval for the sine-rate clkgen) and a restart pulse.
//  It times each note's duration in fs-rate sample ticks, then inserts a muted articulation gap.

---
 rtl/snd_pkg.sv | 21 ++
 rtl/melody_sequencer_note_table.sv | 30 +++
 rtl/melody_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared types and defaults for the melody sequencer and its tone datapath.
package snd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam int AW_DEF    = 5;
   localparam int PW_DEF    = 5;
   localparam int DW_DEF    = 13;
   localparam int GAP_DEF   = 64;
   localparam int FS_MAXVAL = 125;

   typedef struct packed {
      logic [PW_DEF-1:0] pitch;
      logic [DW_DEF-1:0] dur;
   } note_t;

endpackage

// File: rtl/melody_sequencer_note_table.sv
// Note table: DEPTH entries of {pitch, dur}; synchronous write, asynchronous read.
module note_table #(
   parameter int AW = 5,
   parameter int PW = 5,
   parameter int DW = 13
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [PW-1:0] wr_pitch,
   input  logic [DW-1:0] wr_dur,
   input  logic [AW-1:0] rd_addr,
   output logic [PW-1:0] rd_pitch,
   output logic [DW-1:0] rd_dur
);

   localparam int DEPTH = 2 ** AW;

   // Deliberately not reset: table contents survive a sequencer reset.
   logic [PW+DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= {wr_pitch, wr_dur};
      end
   end

   assign {rd_pitch, rd_dur} = mem_q[rd_addr];

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the note table, timing each note and its articulation gap in fs ticks.
// state | meaning
// IDLE  | not playing; waits for start
// PLAY  | current note sounding (muted for rests), counting its duration
// GAP   | muted articulation gap between notes
module melody_sequencer
   import snd_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int PW  = PW_DEF,
   parameter int DW  = DW_DEF,
   parameter int GAP = GAP_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fs_tick,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [PW-1:0] wr_pitch,
   input  logic [DW-1:0] wr_dur,
   input  logic [AW:0]   len,
   input  logic          loop_en,
   input  logic          start,
   input  logic          stop,
   output logic [PW-1:0] pitch_maxval,
   output logic          note_start,
   output logic          sound_en,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_idx
);

   localparam bit            HAS_GAP  = (GAP > 0);
   localparam logic [DW-1:0] GAP_LAST = HAS_GAP ? DW'(GAP - 1) : '0;

   state_e        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [PW-1:0] pitch_q, pitch_d;
   logic [DW-1:0] dur_q, dur_d;
   logic [DW-1:0] ctr_q, ctr_d;
   logic          note_start_q, note_start_d;
   logic          sound_en_q, sound_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_pitch;
   logic [DW-1:0] rd_dur;
   logic          is_last, play_end, gap_end, advance, load_now;

   note_table #(.AW(AW), .PW(PW), .DW(DW)) u_table (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_pitch (wr_pitch),
      .wr_dur   (wr_dur),
      .rd_addr  (rd_addr),
      .rd_pitch (rd_pitch),
      .rd_dur   (rd_dur)
   );

   always_comb begin
      is_last  = ({1'b0, idx_q} == (len_q - 1'b1));
      play_end = fs_tick && (ctr_q == (dur_q - 1'b1));
      gap_end  = fs_tick && (ctr_q == GAP_LAST);
      advance  = ((state_q == ST_PLAY) && play_end && !HAS_GAP) ||
                 ((state_q == ST_GAP) && gap_end);
      // Table is read at the index about to be loaded, so a same-cycle write is not seen.
      rd_addr  = ((state_q == ST_IDLE) || is_last) ? '0 : idx_q + 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      idx_d        = idx_q;
      pitch_d      = pitch_q;
      dur_d        = dur_q;
      ctr_d        = ctr_q;
      sound_en_d   = sound_en_q;
      busy_d       = busy_q;
      note_start_d = 1'b0;
      done_d       = 1'b0;
      load_now     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  len_d    = len;
                  load_now = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (play_end) begin
               ctr_d = '0;
               if (HAS_GAP) begin
                  state_d    = ST_GAP;
                  sound_en_d = 1'b0;
               end
            end else if (fs_tick) begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_end) begin
               ctr_d = '0;
            end else if (fs_tick) begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (is_last && !loop_en) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            sound_en_d = 1'b0;
         end else begin
            load_now = 1'b1;
         end
      end

      if (load_now) begin
         state_d      = ST_PLAY;
         idx_d        = rd_addr;
         pitch_d      = rd_pitch;
         dur_d        = (rd_dur == '0) ? DW'(1) : rd_dur;
         ctr_d        = '0;
         note_start_d = 1'b1;
         busy_d       = 1'b1;
         sound_en_d   = (rd_pitch != '0);
      end

      // Abort overrides everything, including a same-cycle start; pitch is left as is.
      if (stop) begin
         state_d      = ST_IDLE;
         ctr_d        = '0;
         busy_d       = 1'b0;
         sound_en_d   = 1'b0;
         note_start_d = 1'b0;
         done_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         pitch_q      <= '0;
         dur_q        <= '0;
         ctr_q        <= '0;
         note_start_q <= 1'b0;
         sound_en_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         pitch_q      <= pitch_d;
         dur_q        <= dur_d;
         ctr_q        <= ctr_d;
         note_start_q <= note_start_d;
         sound_en_q   <= sound_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign pitch_maxval = pitch_q;
   assign note_start   = note_start_q;
   assign sound_en     = sound_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign cur_idx      = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a note-level model queues expected note/done events, a monitor checks them.
module tb_melody_sequencer;
   import snd_pkg::*;

   localparam int AW = 5, PW = 5, DW = 13, GAP = 2;

   logic          clk = 1'b0;
   logic          reset, fs_tick, wr_en, loop_en, start, stop;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_pitch;
   logic [DW-1:0] wr_dur;
   logic [AW:0]   len;
   logic [PW-1:0] pitch_maxval;
   logic          note_start, sound_en, busy, done;
   logic [AW-1:0] cur_idx;

   melody_sequencer #(.AW(AW), .PW(PW), .DW(DW), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .fs_tick(fs_tick), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_pitch(wr_pitch), .wr_dur(wr_dur), .len(len), .loop_en(loop_en), .start(start),
      .stop(stop), .pitch_maxval(pitch_maxval), .note_start(note_start), .sound_en(sound_en),
      .busy(busy), .done(done), .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 = note load, 1 = done
      int idx;
      int pitch;
      int ticks;  // fs ticks since the previous event, -1 = first of sequence
      int snd;    // of those, ticks with sound on
   } exp_t;

   exp_t  expq[$];
   note_t m_tbl[32];
   int    n_checks = 0, n_errors = 0;
   int    last_total, last_snd;
   bit    seq_first;
   bit    auto_tick = 1'b1, man_tick = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Reference model: a note of duration d occupies max(d,1) ticks, then GAP muted ticks.
   function automatic void begin_seq();
      seq_first = 1'b1;
   endfunction

   function automatic void push_note(input int i);
      exp_t e;
      int   d;
      e.kind  = 0;
      e.idx   = i;
      e.pitch = int'(m_tbl[i].pitch);
      e.ticks = seq_first ? -1 : last_total;
      e.snd   = last_snd;
      seq_first = 1'b0;
      d = (m_tbl[i].dur == 0) ? 1 : int'(m_tbl[i].dur);
      last_total = d + GAP;
      last_snd   = (e.pitch != 0) ? d : 0;
      expq.push_back(e);
   endfunction

   function automatic void push_done();
      exp_t e;
      e.kind  = 1;
      e.idx   = 0;
      e.pitch = 0;
      e.ticks = seq_first ? -1 : last_total;
      e.snd   = last_snd;
      expq.push_back(e);
   endfunction

   function automatic void model_play(input int n_len, input bit lp, input int notes);
      begin_seq();
      if (n_len == 0) begin
         push_done();
      end else begin
         for (int k = 0; k < notes; k++) push_note(k % n_len);
         if (!lp) push_done();
      end
   endfunction

   initial begin
      fs_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fs_tick = auto_tick ? ($urandom_range(0, 3) == 0) : man_tick;
      end
   end

   initial begin : monitor
      exp_t e;
      int   tick_cnt = 0, snd_cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset && (note_start || done)) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: note_start=%0d done=%0d idx=%0d with nothing expected",
                        note_start, done, cur_idx);
            end else begin
               e = expq.pop_front();
               chk("event_kind", note_start ? 0 : 1, e.kind);
               if (e.ticks >= 0) begin
                  chk("ticks_between_events", tick_cnt, e.ticks);
                  chk("sounding_ticks", snd_cnt, e.snd);
               end
               if (e.kind == 0) begin
                  chk("cur_idx", int'(cur_idx), e.idx);
                  chk("pitch_maxval", int'(pitch_maxval), e.pitch);
                  chk("sound_en_at_load", int'(sound_en), (e.pitch != 0) ? 1 : 0);
                  chk("busy_at_load", int'(busy), 1);
               end else begin
                  chk("busy_at_done", int'(busy), 0);
                  chk("sound_en_at_done", int'(sound_en), 0);
               end
            end
            tick_cnt = 0;
            snd_cnt  = 0;
         end
         if (fs_tick) begin
            tick_cnt++;
            if (sound_en) snd_cnt++;
         end
      end
   end

   task automatic drv_write(input int a, input int p, input int d);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = AW'(a); wr_pitch = PW'(p); wr_dur = DW'(d);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic tbl_write(input int a, input int p, input int d);
      drv_write(a, p, d);
      m_tbl[a].pitch = PW'(p);
      m_tbl[a].dur   = DW'(d);
   endtask

   task automatic start_seq(input int n_len, input bit lp);
      @(posedge clk); #1;
      len = (AW+1)'(n_len); loop_en = lp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_stop();
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      chk("busy_after_stop", int'(busy), 0);
      chk("sound_en_after_stop", int'(sound_en), 0);
      chk("done_after_stop", int'(done), 0);
   endtask

   task automatic wait_empty(input int budget, input string what);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (expq.size() != 0) begin
         n_errors++;
         $display("FAIL %s_timeout: got %0d pending events expected 0 after %0d cycles",
                  what, expq.size(), budget);
         expq.delete();
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_basic();
      tbl_write(0, 18, 4);
      tbl_write(1, 13, 2);
      tbl_write(2, 15, 1);
   endtask

   initial begin : main
      int n, l;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
      len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_pitch", int'(pitch_maxval), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sound", int'(sound_en), 0);
      chk("reset_note_start", int'(note_start), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_cur_idx", int'(cur_idx), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: three notes, no loop
      load_basic();
      model_play(3, 1'b0, 3);
      start_seq(3, 1'b0);
      wait_empty(2000, "t1");
      idle_cycles(5);

      // 2: looping, stop after the wrap back to entry 0
      model_play(3, 1'b1, 7);
      start_seq(3, 1'b1);
      wait_empty(4000, "t2");
      do_stop();
      idle_cycles(20);

      // 3: rest and zero-duration note
      tbl_write(0, 0, 3);
      tbl_write(1, 20, 0);
      model_play(2, 1'b0, 2);
      start_seq(2, 1'b0);
      wait_empty(2000, "t3");
      idle_cycles(5);

      // 4: empty sequence, then start with stop in the same cycle
      model_play(0, 1'b0, 0);
      start_seq(0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("len0_busy", int'(busy), 0);
      end
      wait_empty(10, "t4");
      @(posedge clk); #1;
      len = 3; loop_en = 1'b0; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("start_stop_busy", int'(busy), 0);
      end

      // 5: writes during playback; ticks every cycle so the load cycle is known
      load_basic();
      auto_tick = 1'b0; man_tick = 1'b1;
      begin_seq();
      push_note(0); push_note(1); push_note(2);
      m_tbl[1].pitch = 27;
      m_tbl[2].pitch = 9; m_tbl[2].dur = 3;
      push_note(0); push_note(1); push_note(2);
      start_seq(3, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(note_start && cur_idx == 1) && n < 200);
      chk("t5_entry1_seen", (n < 200) ? 1 : 0, 1);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 1; wr_pitch = 27; wr_dur = 2;
      @(negedge clk);
      chk("t5_pitch_held", int'(pitch_maxval), 13);
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      chk("t5_pitch_held2", int'(pitch_maxval), 13);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 2; wr_pitch = 9; wr_dur = 3;
      @(posedge clk); #1;
      wr_en = 1'b0;
      wait_empty(500, "t5");
      do_stop();
      auto_tick = 1'b1; man_tick = 1'b0;
      idle_cycles(10);

      // 6: reset mid-play, then replay to show the table survived
      model_play(3, 1'b0, 3);
      start_seq(3, 1'b0);
      n = 0;
      while (expq.size() > 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      idle_cycles(2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      expq.delete();
      chk("midreset_pitch", int'(pitch_maxval), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_sound", int'(sound_en), 0);
      chk("midreset_cur_idx", int'(cur_idx), 0);
      chk("midreset_done", int'(done), 0);
      idle_cycles(5);
      model_play(3, 1'b0, 3);
      start_seq(3, 1'b0);
      wait_empty(2000, "t6");
      idle_cycles(5);

      // random tables and lengths
      for (int r = 0; r < 6; r++) begin
         l = $urandom_range(1, 6);
         for (int a = 0; a < l; a++) tbl_write(a, $urandom_range(0, 31), $urandom_range(0, 5));
         model_play(l, 1'b0, l);
         start_seq(l, 1'b0);
         wait_empty(3000, "rand");
         idle_cycles(3);
      end

      idle_cycles(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected finish before 900000 ns");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1);
   end

endmodule
